tmds_period_scheduler: RTL and testbench

TMDS_PERIOD_SCHEDULER -- requirements
Module: tmds_period_scheduler

---
 rtl/tmds_period_scheduler_pkg.sv | 30 +++
 rtl/tmds_period_scheduler_if.sv | 28 ++
 rtl/sync_delay_line.sv | 22 ++
 rtl/tmds_period_scheduler.sv | 112 +++++++++++
 tb/tb_tmds_period_scheduler.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/tmds_period_scheduler_pkg.sv
// hdmi_sched_pkg: TMDS period encoding, control-period codes and period lengths
package hdmi_sched_pkg;

    typedef enum logic [2:0] {
        CONTROL,
        VIDEO_PREAMBLE,
        VIDEO_GUARD,
        VIDEO,
        DATA_PREAMBLE,
        DATA_GUARD,
        DATA_ISLAND
    } period_t;

    localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
    localparam logic [3:0] CTL_DATA_PREAMBLE  = 4'b0101;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;

    function automatic logic is_data(period_t m);
        return m inside {DATA_PREAMBLE, DATA_GUARD, DATA_ISLAND};
    endfunction

    function automatic logic [3:0] ctl_code(period_t m);
        return m == VIDEO_PREAMBLE ? CTL_VIDEO_PREAMBLE :
               m == DATA_PREAMBLE  ? CTL_DATA_PREAMBLE  : 4'b0000;
    endfunction

endpackage

// File: rtl/tmds_period_scheduler_if.sv
// tmds_period_scheduler_if: early raster timing and packet request in, period/control/timing out
interface tmds_period_scheduler_if;
    import hdmi_sched_pkg::*;

    logic       de_ahead;
    logic       hsync_ahead;
    logic       vsync_ahead;
    logic       packet_valid;
    logic       packet_ready;
    period_t    mode;
    logic [3:0] ctl;
    logic       de;
    logic       hsync;
    logic       vsync;
    logic [4:0] word_idx;
    logic       sched_err;

    modport master (
        output de_ahead, hsync_ahead, vsync_ahead, packet_valid,
        input  packet_ready, mode, ctl, de, hsync, vsync, word_idx, sched_err
    );

    modport slave (
        input  de_ahead, hsync_ahead, vsync_ahead, packet_valid,
        output packet_ready, mode, ctl, de, hsync, vsync, word_idx, sched_err
    );

endinterface

// File: rtl/sync_delay_line.sv
// sync_delay_line: LEAD-stage shift register aligning early raster timing with the period outputs
module sync_delay_line #(
    parameter int LEAD = 10,
    parameter int W    = 3
) (
    input  logic         clk_pixel,
    input  logic         reset_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [LEAD-1:0][W-1:0] stage_q;

    // Shift one stage per pixel clock
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) stage_q <= '0;
        else          stage_q <= {stage_q[LEAD-2:0], d_i};
    end

    assign q_o = stage_q[LEAD-1];

endmodule

// File: rtl/tmds_period_scheduler.sv
// tmds_period_scheduler: schedules TMDS control/video/data-island periods; islands need HDMI_DATA_ISLAND_EN
module tmds_period_scheduler
    import hdmi_sched_pkg::*;
#(
    parameter int LEAD          = 10,
    parameter int ISLAND_OFFSET = 16,
    parameter int MAX_PACKETS   = 2
) (
    input  logic                   clk_pixel,
    input  logic                   reset_n,
    tmds_period_scheduler_if.slave bus
);

    logic [2:0] sync_dly;
    period_t    mode_q, mode_d;
    logic [4:0] per_cnt_q, per_cnt_d;
    logic [4:0] pkt_cnt_q, pkt_cnt_d;
    logic       de_ahead_q, de_q, hsync_q, vsync_q;
    logic [3:0] ctl_q;
    logic       de_rise, last, island_go;
    int         len;

    sync_delay_line #(.LEAD(LEAD), .W(3)) u_dly (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .d_i       ({bus.vsync_ahead, bus.hsync_ahead, bus.de_ahead}),
        .q_o       (sync_dly)
    );

    // Next period, period timer and packet slot count
    always_comb begin
        de_rise = bus.de_ahead && !de_ahead_q;
        len = (mode_q inside {VIDEO_PREAMBLE, DATA_PREAMBLE}) ? PREAMBLE_LEN :
              (mode_q inside {VIDEO_GUARD, DATA_GUARD})       ? GUARD_LEN    : PACKET_LEN;
        last = per_cnt_q == 5'(len - 1);
        mode_d = mode_q;
        case (mode_q)
            CONTROL:        mode_d = de_rise ? VIDEO_PREAMBLE : island_go ? DATA_PREAMBLE : CONTROL;
            VIDEO_PREAMBLE: mode_d = last ? VIDEO_GUARD : VIDEO_PREAMBLE;
            VIDEO_GUARD:    mode_d = last ? VIDEO : VIDEO_GUARD;
            VIDEO:          mode_d = sync_dly[0] ? VIDEO : CONTROL;
            DATA_PREAMBLE:  mode_d = last ? DATA_GUARD : DATA_PREAMBLE;
            DATA_GUARD:     mode_d = !last ? DATA_GUARD : pkt_cnt_q == '0 ? DATA_ISLAND : CONTROL;
            DATA_ISLAND:    mode_d = (!last || (bus.packet_valid && pkt_cnt_q < 5'(MAX_PACKETS))) ? DATA_ISLAND : DATA_GUARD;
            default:        mode_d = CONTROL;
        endcase
        per_cnt_d = (mode_d != mode_q || last) ? 5'd0 : per_cnt_q + 5'd1;
        pkt_cnt_d = mode_q == CONTROL ? 5'd0 :
                    (mode_d == DATA_ISLAND && per_cnt_d == 5'd0) ? pkt_cnt_q + 5'd1 : pkt_cnt_q;
    end

    // Period state and registered timing/control outputs
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            mode_q                    <= CONTROL;
            per_cnt_q                 <= '0;
            pkt_cnt_q                 <= '0;
            de_ahead_q                <= 1'b0;
            {vsync_q, hsync_q, de_q}  <= '0;
            ctl_q                     <= '0;
        end else begin
            mode_q                    <= mode_d;
            per_cnt_q                 <= per_cnt_d;
            pkt_cnt_q                 <= pkt_cnt_d;
            de_ahead_q                <= bus.de_ahead;
            {vsync_q, hsync_q, de_q}  <= sync_dly;
            ctl_q                     <= ctl_code(mode_d);
        end
    end

    assign bus.mode  = mode_q;
    assign bus.ctl   = ctl_q;
    assign bus.de    = de_q;
    assign bus.hsync = hsync_q;
    assign bus.vsync = vsync_q;

`ifdef HDMI_DATA_ISLAND_EN
    logic [11:0] line_cnt_q;
    logic        line_ok_q, ready_q, err_q;
    logic [4:0]  word_q;

    // Islands start only on a line whose delayed hsync edge has been seen since reset
    assign island_go = line_ok_q && line_cnt_q == 12'(ISLAND_OFFSET) && bus.packet_valid;

    // Line position, slot grant, word index and sticky scheduling error
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            line_cnt_q <= '0;
            line_ok_q  <= 1'b0;
            ready_q    <= 1'b0;
            word_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            line_cnt_q <= (sync_dly[1] && !hsync_q) ? 12'd0 : line_cnt_q + 12'(line_cnt_q != 12'hfff);
            line_ok_q  <= line_ok_q || (sync_dly[1] && !hsync_q);
            ready_q    <= mode_d == DATA_ISLAND && per_cnt_d == 5'd0;
            word_q     <= mode_d == DATA_ISLAND ? per_cnt_d : 5'd0;
            err_q      <= err_q || (de_rise && is_data(mode_q));
        end
    end

    assign bus.packet_ready = ready_q;
    assign bus.word_idx     = word_q;
    assign bus.sched_err    = err_q;
`else
    assign island_go        = 1'b0;
    assign bus.packet_ready = 1'b0;
    assign bus.word_idx     = 5'd0;
    assign bus.sched_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_period_scheduler.sv
// tb_tmds_period_scheduler: directed checks of video timing, sync delay, reset and data islands
module tb_tmds_period_scheduler;
    import hdmi_sched_pkg::*;

    logic clk_pixel = 1'b0;
    logic reset_n   = 1'b0;
    int   n_chk = 0, n_pass = 0, cyc = 0;
    int   data_cnt, rdy_cnt, first_rdy, last_rdy, first_data, hs_at, seen_vp, dp_ctl;
    int   de_at, de_at_word, rst_at_word, rst_hit;
    bit   drop_on_accept, accept_pending;
    logic hs_prev;

    tmds_period_scheduler_if bus();

    tmds_period_scheduler dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic clear();
        data_cnt = 0; rdy_cnt = 0; seen_vp = 0; dp_ctl = -1;
        first_rdy = -1; last_rdy = -1; first_data = -1; hs_at = -1;
    endtask

    task automatic step();
        @(posedge clk_pixel);
        #1;
        cyc++;
        if (bus.mode inside {DATA_PREAMBLE, DATA_GUARD, DATA_ISLAND}) begin
            data_cnt++;
            if (first_data < 0) begin first_data = cyc; dp_ctl = int'(bus.ctl); end
        end
        if (bus.mode == VIDEO_PREAMBLE) seen_vp++;
        if (bus.packet_ready) begin
            rdy_cnt++;
            if (first_rdy < 0) first_rdy = cyc;
            last_rdy = cyc;
        end
        if (bus.hsync && !hs_prev) hs_at = cyc;
        hs_prev = bus.hsync;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_line(int n);
        clear();
        bus.hsync_ahead = 1'b1;
        for (int k = 1; k <= n; k++) begin
            step();
            if (k == 4) bus.hsync_ahead = 1'b0;
            if (drop_on_accept && accept_pending) bus.packet_valid = 1'b0;
            accept_pending = bus.packet_ready && bus.packet_valid;
            if (k == de_at) bus.de_ahead = 1'b1;
            if (de_at_word >= 0 && bus.mode == DATA_ISLAND && bus.word_idx == 5'(de_at_word)) bus.de_ahead = 1'b1;
            if (rst_at_word >= 0 && bus.mode == DATA_ISLAND && bus.word_idx == 5'(rst_at_word)) begin
                rst_hit++;
                reset_n = 1'b0;
                #1;
                check("rst_mode", bus.mode, CONTROL);
                check("rst_ctl", bus.ctl, 0);
                check("rst_word", bus.word_idx, 0);
                check("rst_ready", bus.packet_ready, 0);
                check("rst_err", bus.sched_err, 0);
                check("rst_hsync", bus.hsync, 0);
                #2;
                reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        bus.de_ahead = 1'b0; bus.hsync_ahead = 1'b0; bus.vsync_ahead = 1'b0; bus.packet_valid = 1'b0;
        de_at = -1; de_at_word = -1; rst_at_word = -1; rst_hit = 0;
        drop_on_accept = 1'b0; accept_pending = 1'b0; hs_prev = 1'b0;
        clear();
        #12;
        check("reset_mode", bus.mode, CONTROL);
        check("reset_ctl", bus.ctl, 0);
        check("reset_de", bus.de, 0);
        check("reset_hsync", bus.hsync, 0);
        check("reset_vsync", bus.vsync, 0);
        check("reset_ready", bus.packet_ready, 0);
        check("reset_word", bus.word_idx, 0);
        check("reset_err", bus.sched_err, 0);
        @(posedge clk_pixel);
        #1;
        reset_n = 1'b1;

        idle(19);
        bus.de_ahead = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step();
            check("vid_mode", bus.mode, k < 8 ? VIDEO_PREAMBLE : k < 10 ? VIDEO_GUARD : VIDEO);
            check("vid_ctl", bus.ctl, k < 8 ? 1 : 0);
            check("vid_de", bus.de, k >= 10);
        end
        bus.de_ahead = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            check("vid_end_mode", bus.mode, k < 10 ? VIDEO : CONTROL);
            check("vid_end_de", bus.de, k < 10);
        end

        bus.vsync_ahead = 1'b1;
        bus.hsync_ahead = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) begin bus.vsync_ahead = 1'b0; bus.hsync_ahead = 1'b0; end
            check("vs_dly", bus.vsync, k == 11);
            check("hs_dly", bus.hsync, k == 11);
        end
        idle(40);

        bus.de_ahead = 1'b1;
        idle(15);
        check("pre_rst_mode", bus.mode, VIDEO);
        bus.de_ahead = 1'b0;
        reset_n = 1'b0;
        #1;
        check("async_mode", bus.mode, CONTROL);
        check("async_de", bus.de, 0);
        check("async_ctl", bus.ctl, 0);
        #2;
        reset_n = 1'b1;
        idle(5);
        bus.de_ahead = 1'b1;
        step();
        check("resume_mode", bus.mode, VIDEO_PREAMBLE);
        bus.de_ahead = 1'b0;
        idle(30);

`ifdef HDMI_DATA_ISLAND_EN
        bus.packet_valid = 1'b1;
        run_line(150);
        check("two_data_cycles", data_cnt, 76);
        check("two_ready_pulses", rdy_cnt, 2);
        check("island_start", first_data - hs_at, 17);
        check("first_slot", first_rdy - first_data, 10);
        check("slot_gap", last_rdy - first_rdy, 32);
        check("dp_ctl", dp_ctl, 5);
        check("two_mode_end", bus.mode, CONTROL);

        drop_on_accept = 1'b1;
        run_line(150);
        drop_on_accept = 1'b0;
        check("one_data_cycles", data_cnt, 44);
        check("one_ready_pulses", rdy_cnt, 1);

        bus.packet_valid = 1'b1;
        de_at = 27;
        run_line(100);
        de_at = -1;
        check("prio_data", data_cnt, 0);
        check("prio_ready", rdy_cnt, 0);
        check("prio_vp", seen_vp, 8);
        check("prio_err", bus.sched_err, 0);
        bus.de_ahead = 1'b0;
        idle(30);

        de_at_word = 5;
        run_line(150);
        de_at_word = -1;
        check("err_set", bus.sched_err, 1);
        check("err_data_cycles", data_cnt, 76);
        check("err_no_vp", seen_vp, 0);
        bus.de_ahead = 1'b0;
        idle(30);
        check("err_sticky", bus.sched_err, 1);

        rst_at_word = 10;
        run_line(150);
        rst_at_word = -1;
        check("rst_hit", rst_hit, 1);
        clear();
        idle(100);
        check("post_rst_data", data_cnt, 0);
        check("post_rst_ready", rdy_cnt, 0);
        run_line(150);
        check("resume_data", data_cnt, 76);
        check("resume_ready", rdy_cnt, 2);
`else
        bus.packet_valid = 1'b1;
        run_line(150);
        check("dvi_data", data_cnt, 0);
        check("dvi_ready", rdy_cnt, 0);
        check("dvi_word", bus.word_idx, 0);
        check("dvi_err", bus.sched_err, 0);
        check("dvi_hs_seen", hs_at >= 0, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
